// File: rtl/bank_isu_linefill_tracker.sv
// Bank ISU linefill tracker.
// Keeps a bit per cache set/way that has a linefill outstanding to the BIU.
// Assembles multi-beat BIU read bursts into full lines and hands each line,
// with its set/way, to the ISU issue queue over a valid/ready port.
// Bursts whose first beat carries an id with no linefill outstanding are
// dropped as orphans. Duplicate allocations and orphan bursts raise
// one-cycle error pulses.
module bank_isu_linefill_tracker #(
    parameter int SET_W        = 3,
    parameter int WAY_W        = 3,
    parameter int BEAT_W       = 128,
    parameter int BEATS        = 2,
    parameter int MAX_INFLIGHT = 8,
    localparam int ID_W        = SET_W + WAY_W,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      alloc_valid_i,
    output logic                      alloc_ready_o,
    input  logic [SET_W-1:0]          alloc_set_i,
    input  logic [WAY_W-1:0]          alloc_way_i,

    input  logic [SET_W-1:0]          lookup_set_i,
    input  logic [WAY_W-1:0]          lookup_way_i,
    output logic                      lookup_inflight_o,

    input  logic                      biu_rvalid_i,
    output logic                      biu_rready_o,
    input  logic [ID_W-1:0]           biu_rid_i,
    input  logic [BEAT_W-1:0]         biu_rdata_i,

    output logic                      fill_valid_o,
    input  logic                      fill_ready_i,
    output logic [SET_W-1:0]          fill_set_o,
    output logic [WAY_W-1:0]          fill_way_o,
    output logic [BEATS*BEAT_W-1:0]   fill_data_o,

    output logic [CNT_W-1:0]          inflight_cnt_o,
    output logic                      err_dup_alloc_o,
    output logic                      err_orphan_o
);

    localparam int NUM_IDS = 1 << ID_W;
    localparam int BC_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W  = BEATS * BEAT_W;

    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISCARD,
        S_PRESENT
    } state_t;

    state_t               state_q, state_n;
    logic [BC_W-1:0]      beat_cnt_q, beat_cnt_n;
    logic [NUM_IDS-1:0]   inflight_q, inflight_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [ID_W-1:0]      line_id_q;
    logic [LINE_W-1:0]    line_data_q;
    logic                 fill_valid_q;
    logic                 err_dup_q;
    logic                 err_orphan_q;

    logic [ID_W-1:0]      alloc_id;
    logic [ID_W-1:0]      lookup_id;
    logic                 alloc_hs;
    logic                 beat_hs;
    logic                 fill_hs;
    logic                 same_id_fill;
    logic                 alloc_new;
    logic                 alloc_dup;
    logic                 rid_hit;
    logic                 store_en;
    logic                 latch_id;
    logic                 orphan;

    // Handshake and decode terms, all from registered state plus inputs
    always_comb begin
        alloc_id      = {alloc_set_i, alloc_way_i};
        lookup_id     = {lookup_set_i, lookup_way_i};
        alloc_ready_o = (cnt_q < CNT_MAX);
        biu_rready_o  = (state_q != S_PRESENT);
        lookup_inflight_o = inflight_q[lookup_id];
        alloc_hs      = alloc_valid_i && alloc_ready_o;
        beat_hs       = biu_rvalid_i && biu_rready_o;
        fill_hs       = fill_valid_q && fill_ready_i;
        rid_hit       = inflight_q[biu_rid_i];
        // An alloc that lands on the id being retired this cycle counts as a
        // fresh allocation rather than a duplicate.
        same_id_fill  = fill_hs && (line_id_q == alloc_id);
        alloc_new     = alloc_hs && (!inflight_q[alloc_id] || same_id_fill);
        alloc_dup     = alloc_hs && !alloc_new;
    end

    // In-flight bit vector and outstanding count next-state
    always_comb begin
        inflight_n = inflight_q;
        cnt_n      = cnt_q;
        // Clear before set so a same-id retire/alloc leaves the bit high.
        if (fill_hs) begin
            inflight_n[line_id_q] = 1'b0;
        end
        if (alloc_hs) begin
            inflight_n[alloc_id] = 1'b1;
        end
        case ({alloc_new, fill_hs})
            2'b10:   cnt_n = cnt_q + CNT_W'(1);
            2'b01:   cnt_n = cnt_q - CNT_W'(1);
            default: cnt_n = cnt_q;
        endcase
    end

    // Burst assembly FSM next-state and datapath controls
    always_comb begin
        state_n    = state_q;
        beat_cnt_n = beat_cnt_q;
        store_en   = 1'b0;
        latch_id   = 1'b0;
        orphan     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beat_hs) begin
                    if (rid_hit) begin
                        store_en = 1'b1;
                        latch_id = 1'b1;
                        if (BEATS == 1) begin
                            state_n = S_PRESENT;
                        end else begin
                            state_n    = S_COLLECT;
                            beat_cnt_n = BC_W'(1);
                        end
                    end else begin
                        orphan = 1'b1;
                        if (BEATS != 1) begin
                            state_n    = S_DISCARD;
                            beat_cnt_n = BC_W'(1);
                        end
                    end
                end
            end
            S_COLLECT: begin
                if (beat_hs) begin
                    store_en = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_n    = S_PRESENT;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt_q + BC_W'(1);
                    end
                end
            end
            S_DISCARD: begin
                if (beat_hs) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_n    = S_IDLE;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt_q + BC_W'(1);
                    end
                end
            end
            S_PRESENT: begin
                if (fill_ready_i) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n    = S_IDLE;
                beat_cnt_n = '0;
            end
        endcase
    end

    // Control state, tracking state and registered error pulses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            inflight_q   <= '0;
            cnt_q        <= '0;
            fill_valid_q <= 1'b0;
            err_dup_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            beat_cnt_q   <= beat_cnt_n;
            inflight_q   <= inflight_n;
            cnt_q        <= cnt_n;
            fill_valid_q <= (state_n == S_PRESENT);
            err_dup_q    <= alloc_dup;
            err_orphan_q <= orphan;
        end
    end

    // Line assembly register and latched line address
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            line_id_q   <= '0;
            line_data_q <= '0;
        end else begin
            if (latch_id) begin
                line_id_q <= biu_rid_i;
            end
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (store_en && (beat_cnt_q == BC_W'(k))) begin
                    line_data_q[k*BEAT_W +: BEAT_W] <= biu_rdata_i;
                end
            end
        end
    end

    assign fill_valid_o    = fill_valid_q;
    assign fill_set_o      = line_id_q[ID_W-1:WAY_W];
    assign fill_way_o      = line_id_q[WAY_W-1:0];
    assign fill_data_o     = line_data_q;
    assign inflight_cnt_o  = cnt_q;
    assign err_dup_alloc_o = err_dup_q;
    assign err_orphan_o    = err_orphan_q;

endmodule

// File: tb/tb_bank_isu_linefill_tracker.sv
// Self-checking bench for bank_isu_linefill_tracker at default geometry
// (8 sets, 8 ways, 2 beats of 128 bits, 8 outstanding linefills).
module tb_bank_isu_linefill_tracker;

    logic         clk;
    logic         rst_n;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [2:0]   alloc_set;
    logic [2:0]   alloc_way;
    logic [2:0]   lookup_set;
    logic [2:0]   lookup_way;
    logic         lookup_inflight;
    logic         biu_rvalid;
    logic         biu_rready;
    logic [5:0]   biu_rid;
    logic [127:0] biu_rdata;
    logic         fill_valid;
    logic         fill_ready;
    logic [2:0]   fill_set;
    logic [2:0]   fill_way;
    logic [255:0] fill_data;
    logic [3:0]   inflight_cnt;
    logic         err_dup;
    logic         err_orphan;

    bank_isu_linefill_tracker #(
        .SET_W(3), .WAY_W(3), .BEAT_W(128), .BEATS(2), .MAX_INFLIGHT(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_set_i(alloc_set), .alloc_way_i(alloc_way),
        .lookup_set_i(lookup_set), .lookup_way_i(lookup_way),
        .lookup_inflight_o(lookup_inflight),
        .biu_rvalid_i(biu_rvalid), .biu_rready_o(biu_rready),
        .biu_rid_i(biu_rid), .biu_rdata_i(biu_rdata),
        .fill_valid_o(fill_valid), .fill_ready_i(fill_ready),
        .fill_set_o(fill_set), .fill_way_o(fill_way), .fill_data_o(fill_data),
        .inflight_cnt_o(inflight_cnt),
        .err_dup_alloc_o(err_dup), .err_orphan_o(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   id;
        logic [255:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    bit [63:0]  model_inflight;
    int         model_cnt;
    int         tests;
    int         fails;

    // Scoreboard monitor: a fill handshake occurs at the next rising edge
    // whenever valid and ready are both high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && fill_valid && fill_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL fill_unexpected: got id %h, expected no fill", {fill_set, fill_way});
            end else begin
                mon_e = exp_q.pop_front();
                if ({fill_set, fill_way} !== mon_e.id || fill_data !== mon_e.data) begin
                    fails++;
                    $display("FAIL fill_scoreboard: got id %h data %h, expected id %h data %h",
                             {fill_set, fill_way}, fill_data, mon_e.id, mon_e.data);
                end
                model_inflight[mon_e.id] = 1'b0;
                model_cnt--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lookup(input logic [2:0] s, input logic [2:0] w);
        lookup_set = s;
        lookup_way = w;
        #1;
    endtask

    task automatic apply_reset;
        alloc_valid = 1'b0;
        biu_rvalid  = 1'b0;
        fill_ready  = 1'b0;
        rst_n       = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        model_inflight = '0;
        model_cnt = 0;
        exp_q.delete();
        tick();
    endtask

    // fill_same_id: a fill handshake of this same id occurs in this cycle
    task automatic do_alloc(input logic [2:0] s, input logic [2:0] w, input bit fill_same_id);
        logic [5:0] id;
        bit ready;
        bit dup;
        id    = {s, w};
        ready = (model_cnt < 8);
        dup   = ready && model_inflight[id] && !fill_same_id;
        alloc_valid = 1'b1;
        alloc_set   = s;
        alloc_way   = w;
        tests++;
        if (alloc_ready !== ready) begin
            fails++;
            $display("FAIL alloc_ready: got %b, expected %b (id %h)", alloc_ready, ready, id);
        end
        tick();
        alloc_valid = 1'b0;
        if (ready && !dup) begin
            model_inflight[id] = 1'b1;
            model_cnt++;
        end
        tests++;
        if (err_dup !== dup) begin
            fails++;
            $display("FAIL err_dup_alloc: got %b, expected %b (id %h)", err_dup, dup, id);
        end
        tests++;
        if (inflight_cnt !== 4'(model_cnt)) begin
            fails++;
            $display("FAIL alloc_cnt: got %0d, expected %0d", inflight_cnt, model_cnt);
        end
    endtask

    task automatic send_beat(input logic [5:0] rid, input logic [127:0] data);
        biu_rvalid = 1'b1;
        biu_rid    = rid;
        biu_rdata  = data;
        for (int i = 0; i < 20 && !biu_rready; i++) tick();
        tests++;
        if (biu_rready !== 1'b1) begin
            fails++;
            $display("FAIL beat_accept_timeout: biu_rready %b, expected 1", biu_rready);
        end
        tick();
        biu_rvalid = 1'b0;
        biu_rdata  = '0;
    endtask

    task automatic send_line(input logic [5:0] rid, input bit expect_fill, output logic [255:0] line);
        logic [127:0] a;
        logic [127:0] b;
        exp_t e;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        line = {b, a};
        if (expect_fill) begin
            e.id = rid;
            e.data = line;
            exp_q.push_back(e);
        end
        send_beat(rid, a);
        send_beat(rid, b);
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({alloc_ready, biu_rready, lookup_inflight, fill_valid, err_dup, err_orphan} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 110000",
                     {alloc_ready, biu_rready, lookup_inflight, fill_valid, err_dup, err_orphan});
        end
        tests++;
        if ({fill_set, fill_way} !== 6'd0 || fill_data !== 256'd0) begin
            fails++;
            $display("FAIL reset_fill_bus: got id %h data %h, expected 0", {fill_set, fill_way}, fill_data);
        end
        tests++;
        if (inflight_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d, expected 0", inflight_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alloc_lookup;
        set_lookup(3'd2, 3'd5);
        alloc_set = 3'd2;
        alloc_way = 3'd5;
        alloc_valid = 1'b1;
        #1;
        tests++;
        if (lookup_inflight !== 1'b0) begin
            fails++;
            $display("FAIL lookup_same_cycle: got %b, expected 0", lookup_inflight);
        end
        do_alloc(3'd2, 3'd5, 1'b0);
        #1;
        tests++;
        if (lookup_inflight !== 1'b1) begin
            fails++;
            $display("FAIL lookup_after_alloc: got %b, expected 1", lookup_inflight);
        end
        do_alloc(3'd7, 3'd7, 1'b0);
        tests++;
        if (inflight_cnt !== 4'd2) begin
            fails++;
            $display("FAIL cnt_two_allocs: got %0d, expected 2", inflight_cnt);
        end
        set_lookup(3'd2, 3'd4);
        tests++;
        if (lookup_inflight !== 1'b0) begin
            fails++;
            $display("FAIL lookup_2_4: got %b, expected 0", lookup_inflight);
        end
    endtask

    task automatic test_fill_present;
        logic [255:0] line;
        fill_ready = 1'b0;
        send_line(6'h15, 1'b1, line);
        tests++;
        if (fill_valid !== 1'b1 || fill_set !== 3'd2 || fill_way !== 3'd5 || fill_data !== line) begin
            fails++;
            $display("FAIL fill_first_cycle: got v%b set %0d way %0d data %h, expected v1 set 2 way 5 data %h",
                     fill_valid, fill_set, fill_way, fill_data, line);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (fill_valid !== 1'b1 || {fill_set, fill_way} !== 6'h15 || fill_data !== line || biu_rready !== 1'b0) begin
                fails++;
                $display("FAIL fill_hold: cycle %0d got v%b id %h rready %b, expected v1 id 15 rready 0",
                         i, fill_valid, {fill_set, fill_way}, biu_rready);
            end
        end
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
        set_lookup(3'd2, 3'd5);
        tests++;
        if (inflight_cnt !== 4'd1 || lookup_inflight !== 1'b0 || biu_rready !== 1'b1 || fill_valid !== 1'b0) begin
            fails++;
            $display("FAIL fill_release: got cnt %0d lookup %b rready %b valid %b, expected cnt 1 lookup 0 rready 1 valid 0",
                     inflight_cnt, lookup_inflight, biu_rready, fill_valid);
        end
    endtask

    task automatic test_full;
        logic [255:0] line;
        for (int k = 0; k < 7; k++) do_alloc(3'd4, 3'(k), 1'b0);
        tests++;
        if (alloc_ready !== 1'b0 || inflight_cnt !== 4'd8) begin
            fails++;
            $display("FAIL full_backpressure: got ready %b cnt %0d, expected ready 0 cnt 8", alloc_ready, inflight_cnt);
        end
        do_alloc(3'd5, 3'd0, 1'b0);
        set_lookup(3'd5, 3'd0);
        tests++;
        if (lookup_inflight !== 1'b0) begin
            fails++;
            $display("FAIL full_rejected_lookup: got %b, expected 0", lookup_inflight);
        end
        fill_ready = 1'b1;
        send_line(6'h20, 1'b1, line);
        tests++;
        if (fill_valid !== 1'b1 || alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_present: got valid %b ready %b, expected valid 1 ready 0", fill_valid, alloc_ready);
        end
        tick();
        fill_ready = 1'b0;
        tests++;
        if (alloc_ready !== 1'b1 || inflight_cnt !== 4'd7) begin
            fails++;
            $display("FAIL full_recover: got ready %b cnt %0d, expected ready 1 cnt 7", alloc_ready, inflight_cnt);
        end
    endtask

    task automatic test_dup;
        apply_reset();
        do_alloc(3'd3, 3'd3, 1'b0);
        do_alloc(3'd3, 3'd3, 1'b0);
        tests++;
        if (inflight_cnt !== 4'd1) begin
            fails++;
            $display("FAIL dup_cnt: got %0d, expected 1", inflight_cnt);
        end
        tick();
        tests++;
        if (err_dup !== 1'b0) begin
            fails++;
            $display("FAIL dup_pulse_width: got %b, expected 0", err_dup);
        end
    endtask

    task automatic test_orphan;
        logic [255:0] line;
        send_beat(6'h3F, 128'hAAAA);
        tests++;
        if (err_orphan !== 1'b1) begin
            fails++;
            $display("FAIL orphan_pulse: got %b, expected 1", err_orphan);
        end
        send_beat(6'h3F, 128'hBBBB);
        tests++;
        if (err_orphan !== 1'b0 || fill_valid !== 1'b0) begin
            fails++;
            $display("FAIL orphan_drop: got err %b valid %b, expected 0 0", err_orphan, fill_valid);
        end
        tick();
        tests++;
        if (fill_valid !== 1'b0 || inflight_cnt !== 4'd1) begin
            fails++;
            $display("FAIL orphan_after: got valid %b cnt %0d, expected 0 1", fill_valid, inflight_cnt);
        end
        fill_ready = 1'b1;
        send_line(6'h1B, 1'b1, line);
        tests++;
        if (fill_valid !== 1'b1 || err_orphan !== 1'b0) begin
            fails++;
            $display("FAIL orphan_then_line: got valid %b err %b, expected 1 0", fill_valid, err_orphan);
        end
        tick();
        fill_ready = 1'b0;
    endtask

    task automatic test_same_cycle;
        logic [255:0] line;
        apply_reset();
        do_alloc(3'd1, 3'd1, 1'b0);
        do_alloc(3'd6, 3'd2, 1'b0);
        send_line(6'h09, 1'b1, line);
        fill_ready = 1'b1;
        do_alloc(3'd1, 3'd1, 1'b1);
        fill_ready = 1'b0;
        set_lookup(3'd1, 3'd1);
        tests++;
        if (inflight_cnt !== 4'd2 || lookup_inflight !== 1'b1 || fill_valid !== 1'b0) begin
            fails++;
            $display("FAIL same_id_fill_alloc: got cnt %0d lookup %b valid %b, expected 2 1 0",
                     inflight_cnt, lookup_inflight, fill_valid);
        end
        send_line(6'h32, 1'b1, line);
        fill_ready = 1'b1;
        do_alloc(3'd0, 3'd4, 1'b0);
        fill_ready = 1'b0;
        set_lookup(3'd6, 3'd2);
        tests++;
        if (inflight_cnt !== 4'd2 || lookup_inflight !== 1'b0) begin
            fails++;
            $display("FAIL diff_id_fill_alloc: got cnt %0d lookup_6_2 %b, expected 2 0", inflight_cnt, lookup_inflight);
        end
        set_lookup(3'd0, 3'd4);
        tests++;
        if (lookup_inflight !== 1'b1) begin
            fails++;
            $display("FAIL diff_id_new_lookup: got %b, expected 1", lookup_inflight);
        end
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        do_alloc(3'd2, 3'd2, 1'b0);
        send_beat(6'h12, 128'h1111);
        set_lookup(3'd2, 3'd2);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({alloc_ready, biu_rready, lookup_inflight, fill_valid, err_dup, err_orphan} !== 6'b110000 ||
            inflight_cnt !== 4'd0 || fill_data !== 256'd0) begin
            fails++;
            $display("FAIL reset_mid_burst: got flags %b cnt %0d, expected 110000 cnt 0",
                     {alloc_ready, biu_rready, lookup_inflight, fill_valid, err_dup, err_orphan}, inflight_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_inflight = '0;
        model_cnt = 0;
        exp_q.delete();
        tick();
        send_beat(6'h12, 128'h2222);
        tests++;
        if (err_orphan !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_orphan: got %b, expected 1", err_orphan);
        end
        send_beat(6'h12, 128'h3333);
        tests++;
        if (fill_valid !== 1'b0 || err_orphan !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_drop: got valid %b err %b, expected 0 0", fill_valid, err_orphan);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] line;
        do_alloc(3'd5, 3'd1, 1'b0);
        do_alloc(3'd5, 3'd2, 1'b0);
        fill_ready = 1'b1;
        send_line(6'h29, 1'b1, line);
        send_line(6'h2A, 1'b1, line);
        tests++;
        if (fill_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_valid: got %b, expected 1", fill_valid);
        end
        tick();
        fill_ready = 1'b0;
        tests++;
        if (inflight_cnt !== 4'd0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: got cnt %0d pending %0d, expected 0 0", inflight_cnt, exp_q.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_inflight = '0;
        model_cnt = 0;
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        alloc_set = '0;
        alloc_way = '0;
        lookup_set = '0;
        lookup_way = '0;
        biu_rvalid = 1'b0;
        biu_rid = '0;
        biu_rdata = '0;
        fill_ready = 1'b0;

        test_reset();
        test_alloc_lookup();
        test_fill_present();
        test_full();
        test_dup();
        test_orphan();
        test_same_cycle();
        test_reset_mid_burst();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
